mem_wb_pipe: RTL and testbench

Parametrised MEM→WB pipeline register for the full pipeline, successor to the single-stage memory latch. Carries destination register, control signals, load data and ALU result through DEPTH register stages with per-stage valid bits, stall (hold) and flush (squash) control. It computes the write-back value and exposes a two-port forwarding lookup across all in-flight stages for the hazard/forwarding unit.

---
 rtl/mem_wb_pipe.sv | 96 +++++++++
 tb/tb_mem_wb_pipe.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: DEPTH-stage MEM->WB pipeline register with stall/flush, write-back mux and forwarding lookup
module mem_wb_pipe #(
  parameter int DATA_W       = 32,
  parameter int RD_W         = 4,
  parameter int SIG_W        = 11,
  parameter int DEPTH        = 1,
  parameter int REGWRITE_BIT = 0,
  parameter int MEMTOREG_BIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  input  logic [RD_W-1:0]   rd,
  input  logic [SIG_W-1:0]  signals,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] alu_result,
  output logic              valid_out,
  output logic [RD_W-1:0]   rd_out,
  output logic [SIG_W-1:0]  sign_out,
  output logic [DATA_W-1:0] read_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_en,
  input  logic [RD_W-1:0]   q_rs1,
  input  logic [RD_W-1:0]   q_rs2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2
);
  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("mem_wb_pipe: DEPTH must be in 1..4");
  end
  logic              v_q   [DEPTH];
  logic [RD_W-1:0]   rd_q  [DEPTH];
  logic [SIG_W-1:0]  sig_q [DEPTH];
  logic [DATA_W-1:0] rdat_q[DEPTH];
  logic [DATA_W-1:0] alu_q [DATA_W > 0 ? DEPTH : 1];
  logic [DATA_W-1:0] wbv_q [DEPTH];
  logic [DATA_W-1:0] wbv_in;
  assign wbv_in = signals[MEMTOREG_BIT] ? read_data : alu_result;
  // stage shift: flush clears valids but still loads data, stall holds everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        v_q[k]    <= 1'b0;
        rd_q[k]   <= '0;
        sig_q[k]  <= '0;
        rdat_q[k] <= '0;
        alu_q[k]  <= '0;
        wbv_q[k]  <= '0;
      end
    end else if (flush || !stall) begin
      v_q[0]    <= valid_in & ~flush;
      rd_q[0]   <= rd;
      sig_q[0]  <= signals;
      rdat_q[0] <= read_data;
      alu_q[0]  <= alu_result;
      wbv_q[0]  <= wbv_in;
      for (int k = 1; k < DEPTH; k++) begin
        v_q[k]    <= v_q[k-1] & ~flush;
        rd_q[k]   <= rd_q[k-1];
        sig_q[k]  <= sig_q[k-1];
        rdat_q[k] <= rdat_q[k-1];
        alu_q[k]  <= alu_q[k-1];
        wbv_q[k]  <= wbv_q[k-1];
      end
    end
  end
  assign valid_out = v_q[DEPTH-1];
  assign rd_out    = rd_q[DEPTH-1];
  assign sign_out  = sig_q[DEPTH-1];
  assign read_out  = rdat_q[DEPTH-1];
  assign alu_out   = alu_q[DEPTH-1];
  assign wb_data   = wbv_q[DEPTH-1];
  assign wb_en     = v_q[DEPTH-1] & sig_q[DEPTH-1][REGWRITE_BIT];
  // forwarding lookup: scan oldest to youngest so the youngest match overrides
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (v_q[k] && sig_q[k][REGWRITE_BIT] && rd_q[k] == q_rs1) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = wbv_q[k];
      end
      if (v_q[k] && sig_q[k][REGWRITE_BIT] && rd_q[k] == q_rs2) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = wbv_q[k];
      end
    end
  end
endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: DEPTH=1/2/3 instances checked against an in-flight-list model plus directed literals
module tb_mem_wb_pipe;
  logic clk, rst_n, valid_in, stall, flush;
  logic [3:0] rd, q_rs1, q_rs2;
  logic [10:0] signals;
  logic [31:0] read_data, alu_result;
  logic vo[3], wbe[3], h1[3], h2[3];
  logic [3:0] rdo[3];
  logic [10:0] so[3];
  logic [31:0] ro[3], ao[3], wbd[3], fd1[3], fd2[3];
  int tests = 0, fails = 0;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_wb_pipe #(.DEPTH(g + 1)) u (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall), .flush(flush),
      .rd(rd), .signals(signals), .read_data(read_data), .alu_result(alu_result),
      .valid_out(vo[g]), .rd_out(rdo[g]), .sign_out(so[g]), .read_out(ro[g]),
      .alu_out(ao[g]), .wb_data(wbd[g]), .wb_en(wbe[g]), .q_rs1(q_rs1), .q_rs2(q_rs2),
      .fwd_hit1(h1[g]), .fwd_hit2(h2[g]), .fwd_data1(fd1[g]), .fwd_data2(fd2[g])
    );
  end
  always #5 clk = ~clk;
  typedef struct {
    bit v;
    logic [3:0] rd;
    logic [10:0] sig;
    logic [31:0] rdat, alu;
  } bnd_t;
  bnd_t m[3][4];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  function automatic logic [31:0] wbv(input bnd_t b);
    return b.sig[1] ? b.rdat : b.alu;
  endfunction
  // model: each depth keeps its in-flight list, youngest at index 0; reset empties it
  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 3; d++)
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) m[d][k] = '{default: 0};
      end else if (flush || !stall) begin
        for (int k = 3; k > 0; k--) m[d][k] = m[d][k-1];
        m[d][0] = '{valid_in, rd, signals, read_data, alu_result};
        if (flush) for (int k = 0; k < 4; k++) m[d][k].v = 0;
      end
  end
  // compare every instance against the model shortly after each rising edge
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 3; d++) begin
      bnd_t l;
      logic eh1, eh2;
      logic [31:0] ed1, ed2;
      l = m[d][d];
      eh1 = 0; eh2 = 0; ed1 = 0; ed2 = 0;
      for (int k = d; k >= 0; k--) begin
        if (m[d][k].v && m[d][k].sig[0] && m[d][k].rd == q_rs1) begin eh1 = 1; ed1 = wbv(m[d][k]); end
        if (m[d][k].v && m[d][k].sig[0] && m[d][k].rd == q_rs2) begin eh2 = 1; ed2 = wbv(m[d][k]); end
      end
      chk($sformatf("d%0d.valid_out", d + 1), 32'(vo[d]), 32'(l.v));
      chk($sformatf("d%0d.rd_out", d + 1), 32'(rdo[d]), 32'(l.rd));
      chk($sformatf("d%0d.sign_out", d + 1), 32'(so[d]), 32'(l.sig));
      chk($sformatf("d%0d.read_out", d + 1), ro[d], l.rdat);
      chk($sformatf("d%0d.alu_out", d + 1), ao[d], l.alu);
      chk($sformatf("d%0d.wb_data", d + 1), wbd[d], wbv(l));
      chk($sformatf("d%0d.wb_en", d + 1), 32'(wbe[d]), 32'(l.v & l.sig[0]));
      chk($sformatf("d%0d.fwd_hit1", d + 1), 32'(h1[d]), 32'(eh1));
      chk($sformatf("d%0d.fwd_hit2", d + 1), 32'(h2[d]), 32'(eh2));
      chk($sformatf("d%0d.fwd_data1", d + 1), fd1[d], ed1);
      chk($sformatf("d%0d.fwd_data2", d + 1), fd2[d], ed2);
    end
  end
  task automatic cyc(input logic v, input logic [3:0] r, input logic [10:0] s,
                     input logic [31:0] rdv, input logic [31:0] av, input logic st, input logic fl);
    valid_in = v; rd = r; signals = s; read_data = rdv; alu_result = av; stall = st; flush = fl;
    @(posedge clk);
    @(negedge clk);
  endtask
  // directed scenarios with literal expectations, then randomized traffic
  initial begin
    clk = 0; rst_n = 0; valid_in = 1; rd = 5; signals = 11'h1; read_data = 0; alu_result = 32'h55;
    stall = 0; flush = 0; q_rs1 = 5; q_rs2 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.valid_out", 32'(vo[0]), 0);
    chk("rst.rd_out", 32'(rdo[0]), 0);
    chk("rst.wb_en", 32'(wbe[0]), 0);
    chk("rst.fwd_hit1", 32'(h1[0]), 0);
    chk("rst.wb_data", wbd[2], 0);
    rst_n = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rel.valid_out", 32'(vo[0]), 1);
    chk("rel.rd_out", 32'(rdo[0]), 5);
    cyc(1, 1, 11'h1, 0, 32'h11, 0, 0);
    cyc(1, 2, 11'h1, 0, 32'h22, 0, 0);
    cyc(1, 3, 11'h1, 0, 32'h33, 0, 0);
    chk("pt.rd_out1", 32'(rdo[2]), 1);
    chk("pt.wb_data1", wbd[2], 32'h11);
    chk("pt.wb_en1", 32'(wbe[2]), 1);
    cyc(1, 4, 11'h3, 32'hDEADBEEF, 32'h1234, 0, 0);
    chk("pt.rd_out2", 32'(rdo[2]), 2);
    chk("mux.wb_data", wbd[0], 32'hDEADBEEF);
    chk("mux.alu_out", ao[0], 32'h1234);
    chk("mux.read_out", ro[0], 32'hDEADBEEF);
    cyc(1, 6, 11'h1, 0, 32'h66, 0, 0);
    chk("pt.rd_out3", 32'(rdo[2]), 3);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 9, 11'h1, 0, 32'h99, 1, 0);
      chk($sformatf("stall.rd_out%0d", i), 32'(rdo[1]), 4);
      chk($sformatf("stall.wb_data%0d", i), wbd[1], 32'hDEADBEEF);
    end
    cyc(0, 0, 11'h0, 0, 0, 0, 0);
    chk("stall.resume", 32'(rdo[1]), 6);
    cyc(1, 8, 11'h1, 0, 32'h88, 0, 0);
    cyc(1, 9, 11'h1, 0, 32'h99, 0, 0);
    q_rs1 = 8; q_rs2 = 9;
    cyc(1, 8, 11'h1, 0, 32'h77, 1, 1);
    chk("flush.valid_out", 32'(vo[1]), 0);
    chk("flush.wb_en", 32'(wbe[1]), 0);
    chk("flush.hit1", 32'(h1[2]), 0);
    chk("flush.hit2", 32'(h2[2]), 0);
    cyc(1, 10, 11'h1, 0, 32'hAA, 0, 0);
    chk("flush.d1_new", 32'(rdo[0]), 10);
    chk("flush.d3_empty", 32'(vo[2]), 0);
    cyc(0, 0, 11'h0, 0, 0, 0, 0);
    cyc(0, 0, 11'h0, 0, 0, 0, 0);
    chk("flush.d3_valid", 32'(vo[2]), 1);
    chk("flush.d3_rd", 32'(rdo[2]), 10);
    q_rs1 = 7; q_rs2 = 9;
    cyc(1, 7, 11'h1, 0, 32'hB, 0, 0);
    cyc(1, 3, 11'h1, 0, 32'hC, 0, 0);
    cyc(1, 7, 11'h1, 0, 32'hA, 0, 0);
    chk("fwd.hit1", 32'(h1[2]), 1);
    chk("fwd.data1_young", fd1[2], 32'hA);
    chk("fwd.hit2", 32'(h2[2]), 0);
    chk("fwd.data2", fd2[2], 0);
    cyc(1, 7, 11'h1, 0, 32'hB, 0, 0);
    cyc(1, 3, 11'h1, 0, 32'hC, 0, 0);
    cyc(1, 7, 11'h0, 0, 32'hA, 0, 0);
    chk("fwd.data1_old", fd1[2], 32'hB);
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(99) != 0;
      q_rs1 = 4'($urandom_range(7));
      q_rs2 = 4'($urandom_range(7));
      cyc(1'($urandom_range(3) != 0), 4'($urandom_range(7)), 11'($urandom), $urandom, $urandom,
          $urandom_range(4) == 0, $urandom_range(19) == 0);
    end
    rst_n = 1;
    cyc(0, 0, 11'h0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
